// File: rtl/instruction_loader.sv
// ============================================================================
// Module   : instruction_loader
// Purpose  : Byte-stream boot loader that fills instruction memory before the
//            core runs (little-endian word count, then 32-bit words).
// Revision : 1.0
// ============================================================================
`default_nettype none

module instruction_loader #(
  parameter int MEM_WORDS      = 256,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  input  logic        reload,
  output logic        we,
  output logic [31:0] ADDR_INST,
  output logic [31:0] Instrucoes,
  output logic        clk_load,
  output logic        done,
  output logic        error
);

  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GAP_W-1:0] C_TIMEOUT  = GAP_W'(TIMEOUT_CYCLES);
  localparam logic [31:0]      C_MEM_WORDS = 32'(MEM_WORDS);

  typedef enum logic [2:0] {
    S_HDR0  = 3'd0,
    S_HDR1  = 3'd1,
    S_BYTE  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [15:0]       word_idx_q, word_idx_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       instr_q, instr_d;

  logic              w_accept;
  logic [15:0]       w_hdr_count;
  logic [15:0]       w_next_word;
  logic [GAP_W-1:0]  w_gap_inc;
  logic              w_timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_HDR0;
      count_q    <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      gap_q      <= '0;
      addr_q     <= '0;
      instr_q    <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      gap_q      <= gap_d;
      addr_q     <= addr_d;
      instr_q    <= instr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    gap_d      = gap_q;
    addr_d     = addr_q;
    instr_d    = instr_q;

    byte_ready = (state_q == S_HDR0) || (state_q == S_HDR1) || (state_q == S_BYTE);
    w_accept   = byte_valid && byte_ready;

    w_hdr_count = {byte_data, count_q[7:0]};
    w_next_word = word_idx_q + 16'd1;
    w_gap_inc   = gap_q + {{(GAP_W-1){1'b0}}, 1'b1};
    w_timeout   = (w_gap_inc == C_TIMEOUT);

    case (state_q)
      S_HDR0: begin
        // Idle forever here: no gap counting before the first header byte.
        if (w_accept) begin
          count_d[7:0] = byte_data;
          gap_d        = '0;
          state_d      = S_HDR1;
        end
      end

      S_HDR1: begin
        if (w_accept) begin
          count_d[15:8] = byte_data;
          gap_d         = '0;
          if (w_hdr_count == 16'd0) begin
            state_d = S_DONE;
          end else if ({16'd0, w_hdr_count} > C_MEM_WORDS) begin
            state_d = S_ERR;
          end else begin
            word_idx_d = '0;
            byte_idx_d = '0;
            addr_d     = '0;
            state_d    = S_BYTE;
          end
        end else if (w_timeout) begin
          state_d = S_ERR;
        end else begin
          gap_d = w_gap_inc;
        end
      end

      S_BYTE: begin
        if (w_accept) begin
          instr_d[{byte_idx_q, 3'b000} +: 8] = byte_data;
          byte_idx_d = byte_idx_q + 2'd1;
          gap_d      = '0;
          if (byte_idx_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end else if (w_timeout) begin
          state_d = S_ERR;
        end else begin
          gap_d = w_gap_inc;
        end
      end

      S_WRITE: begin
        word_idx_d = w_next_word;
        if (w_next_word == count_q) begin
          state_d = S_DONE;
        end else begin
          byte_idx_d = '0;
          gap_d      = '0;
          addr_d     = {14'd0, w_next_word, 2'b00};
          state_d    = S_BYTE;
        end
      end

      S_DONE, S_ERR: begin
        if (reload) begin
          state_d    = S_HDR0;
          count_d    = '0;
          word_idx_d = '0;
          byte_idx_d = '0;
          gap_d      = '0;
          addr_d     = '0;
          instr_d    = '0;
        end
      end

      default: begin
        state_d = S_HDR0;
      end
    endcase
  end

  // Outputs decode straight from state so an async reset takes effect at once.
  assign we         = (state_q != S_DONE);
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERR);
  assign clk_load   = (state_q == S_WRITE);
  assign ADDR_INST  = addr_q;
  assign Instrucoes = instr_q;

endmodule

`default_nettype wire

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
Byte-stream boot loader that fills instruction memory before the core runs. It receives a little-endian word count followed by little-endian 32-bit instruction words, and drives the memory write side: we, ADDR_INST, Instrucoes and the clk_load strobe. It holds we high for the whole load, which keeps the fetch stage parked at PC 0. It then releases we so execution starts from address 0.

Parameters:
MEM_WORDS, 256, capacity of instruction memory in 32-bit words; a larger header count is an error.
TIMEOUT_CYCLES, 100000, maximum idle cycles between accepted bytes once a load has begun.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
byte_valid  input  1  byte_data is valid this cycle
byte_data  input  8  incoming stream byte
byte_ready  output  1  loader accepts a byte this cycle
reload  input  1  one-cycle request to start a new load from DONE or ERR
we  output  1  load in progress; fetch stage uses ADDR_INST instead of PC while high
ADDR_INST  output  32  byte address of the word being written
Instrucoes  output  32  assembled instruction word
clk_load  output  1  one-cycle write strobe to instruction memory
done  output  1  load completed successfully
error  output  1  load aborted (overflow or timeout)

Behaviour:
- One clock. Reset is asynchronous and active-high.
- Reset values: state=HDR0, we=1, ADDR_INST=0, Instrucoes=0, clk_load=0, done=0, error=0, byte_ready=1. All internal counters are 0.
- A byte is accepted on a rising edge where byte_valid && byte_ready.
- States:
  - HDR0: accept count[7:0] -> HDR1. No timeout in this state; the loader waits indefinitely.
  - HDR1: accept count[15:8]. Then:
    - count==0 -> DONE.
    - count>MEM_WORDS -> ERR.
    - otherwise -> BYTE, with word_idx=0 and byte_idx=0.
  - BYTE: the accepted byte goes to Instrucoes[8*byte_idx+7 : 8*byte_idx]. byte_idx increments. The 4th byte (byte_idx==3) -> WRITE.
  - WRITE:
    - byte_ready=0 and clk_load=1 for exactly one cycle.
    - ADDR_INST = word_idx*4 (zero-extended to 32 bits). ADDR_INST is set on entry to BYTE for the word and stays stable through the strobe.
    - Next cycle: word_idx+1. If word_idx+1==count -> DONE, else BYTE with byte_idx=0.
  - DONE: we=0, done=1, byte_ready=0. reload -> HDR0.
  - ERR: we=1, error=1, byte_ready=0. reload -> HDR0.
- On the transition to HDR0 from reload: done=0, error=0, we=1, ADDR_INST=0, Instrucoes=0, all counters cleared. reload is ignored in every other state.
- Timeout:
  - The gap counter clears on every accepted byte and on entry to HDR1/BYTE.
  - It increments in HDR1 and BYTE while no byte is accepted.
  - Reaching TIMEOUT_CYCLES -> ERR.
  - The counter is frozen in HDR0, WRITE, DONE and ERR.
- byte_valid is ignored while byte_ready=0. The sender must hold the byte; the loader never drops a presented byte.
- Asserting rst mid-load returns to reset values immediately. A partially written memory is then overwritten by the next load.
- clk_load never asserts outside WRITE. we never falls except on entry to DONE.

Test Plan:
- Reset, then stream 02 00 13 00 00 00 93 00 10 00 -> clk_load pulses twice: ADDR_INST=0x0 with Instrucoes=0x00000013, then ADDR_INST=0x4 with Instrucoes=0x00100093. After the second pulse: we=0, done=1, error=0.
- Stream header 00 00 -> no clk_load pulse. DONE on the cycle after the 2nd byte, with we=0.
- MEM_WORDS=256, header 01 01 (count=257) -> ERR, with error=1, we=1, no clk_load pulse. A reload pulse then returns to HDR0 with error=0.
- TIMEOUT_CYCLES=16: header 01 00, then 2 bytes, then byte_valid held low for 16 cycles -> error=1, no clk_load pulse. In HDR0, a 1000-cycle idle gap causes no error.
- byte_valid held high continuously with back-to-back bytes -> byte_ready=0 for exactly one cycle per word (WRITE). No byte is lost, so the written word values match the stream.
- rst asserted in the cycle between bytes 2 and 3 of word 1 -> outputs return to reset values asynchronously. A fresh full load afterwards completes correctly, with ADDR_INST starting at 0.
